seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It holds a 16-bit display value, scans the four digits in turn, and presents each digit's nibble to the combinational hex-to-segment decoder. It takes the decoder's active-low segment pattern back, applies decimal-point and leading-zero blanking, inserts anti-ghosting dead time, and drives registered segment and anode outputs to the pins.

---
 rtl/seven_seg_scanner.sv | 94 +++++++++
 tb/tb_seven_seg_scanner.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit common-anode driver with tear-free value update.
// Pins lag the scan counters by one cycle; no backpressure, load is a fire-and-forget strobe.
module seven_seg_scanner #(
  parameter int PRESCALE = 12000,
  parameter int BLANK    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  nibble_out,
  input  logic [7:0]  seg_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  dig_out,
  output logic        frame_done
);

  localparam int            CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   pending;
  logic          pending_v;

  logic          slot_end;
  logic          wrap;
  logic [15:0]   upper;
  logic          lz_blank;
  logic [7:0]    seg_n;
  logic [3:0]    dig_n;

  // The decoder always drives its dp bit high; ours comes from dp_in instead.
  logic          unused_seg_dp;
  assign unused_seg_dp = seg_in[7];

  always_comb begin
    slot_end = (cnt == CNT_LAST);
    wrap     = slot_end && (idx == 2'd3);
    // Current digit and everything above it; zero means the digit is a leading zero.
    upper    = shadow >> {idx, 2'b00};
    lz_blank = blank_lz && (idx != 2'd0) && (upper == 16'h0000);
    seg_n    = {~dp_in[idx], lz_blank ? 7'h7F : seg_in[6:0]};
    dig_n    = ~(4'b0001 << idx);
  end

  assign nibble_out = upper[3:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      pending    <= 16'h0000;
      pending_v  <= 1'b0;
      seg_out    <= 8'hFF;
      dig_out    <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= idx + 2'd1;
      end

      // Shadow only moves at the frame boundary; a load landing on it bypasses pending.
      if (wrap) begin
        if (load) begin
          shadow <= value_in;
        end else if (pending_v) begin
          shadow <= pending;
        end
        pending_v <= 1'b0;
      end else if (load) begin
        pending   <= value_in;
        pending_v <= 1'b1;
      end

      if (cnt < CNT_BLANK) begin
        seg_out <= 8'hFF;
        dig_out <= 4'hF;
      end else begin
        seg_out <= seg_n;
        dig_out <= dig_n;
      end

      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: reference model tracks elapsed cycles since reset and the latest load.
module tb_seven_seg_scanner;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble_out;
  logic [7:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  dig_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [3:0] low_at(input int d);
    logic [1:0] s;
    s = d[1:0];
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [3:0] digit_of(input logic [15:0] v, input int slot);
    logic [15:0] t;
    t = v >> (4 * slot);
    return t[3:0];
  endfunction

  assign seg_in = hex7(nibble_out);

  seven_seg_scanner #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .resetn(resetn), .value_in(value_in), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .nibble_out(nibble_out), .seg_in(seg_in), .seg_out(seg_out),
    .dig_out(dig_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference: k counts cycles since reset release; a frame boundary adopts the latest load seen.
  int          k = 0;
  logic [15:0] shown = 16'h0000;
  logic [15:0] latest = 16'h0000;
  bit          have = 1'b0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_dig = 4'hF;
  logic        exp_fd = 1'b0;
  logic [3:0]  exp_nib = 4'h0;

  always @(posedge clk) begin
    int          slot;
    int          ph;
    logic [7:0]  d;
    logic [15:0] up;
    if (!resetn) begin
      k = 0; shown = 16'h0000; latest = 16'h0000; have = 1'b0;
      exp_seg = 8'hFF; exp_dig = 4'hF; exp_fd = 1'b0;
    end else begin
      slot = (k / P) % 4;
      ph   = k % P;
      up   = shown >> (4 * slot);
      if (ph < B) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        d = hex7(up[3:0]);
        if (blank_lz && slot > 0 && up == 16'h0000) d[6:0] = 7'h7F;
        d[7] = ~dp_in[slot];
        exp_seg = d;
        exp_dig = low_at(slot);
      end
      exp_fd = (slot == 3 && ph == P - 1);
      if (load) begin
        latest = value_in;
        have   = 1'b1;
      end
      if (exp_fd && have) begin
        shown = latest;
        have  = 1'b0;
      end
      k++;
    end
    exp_nib = digit_of(shown, (k / P) % 4);
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int slot, input int ph);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((k / P) % 4) == slot && (k % P) == ph) break;
      tick();
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; value_in = 16'hFFFF; load = 1'b1;
    tick(); tick();
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg_out); end
    checks++; if (dig_out !== 4'hF) begin errors++; $display("FAIL reset_dig got %b want 1111", dig_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    checks++; if (nibble_out !== 4'h0) begin errors++; $display("FAIL reset_nib got %h want 0", nibble_out); end
    load = 1'b0; resetn = 1'b1;
    for (int i = 0; i < B; i++) begin
      tick();
      checks++;
      if (dig_out !== 4'hF || seg_out !== 8'hFF) begin
        errors++; $display("FAIL reset_dark i=%0d got seg=%h dig=%b want ff 1111", i, seg_out, dig_out);
      end
    end
    tick();
    checks++;
    if (dig_out !== 4'b1110 || seg_out !== 8'hC0) begin
      errors++; $display("FAIL reset_first_lit got seg=%h dig=%b want c0 1110", seg_out, dig_out);
    end
  endtask

  task automatic test_scan();
    int          lows[4];
    int          dark;
    int          fd_at[$];
    logic [7:0]  pseg;
    logic [3:0]  wn;
    for (int d = 0; d < 4; d++) lows[d] = 0;
    dark = 0;
    goto(3, P - 1);
    pulse_load(16'h1234);
    for (int i = 0; i < 2 * FRAME; i++) begin
      pseg = seg_in;
      tick();
      checks++;
      if ({seg_out, dig_out, frame_done, nibble_out} !== {exp_seg, exp_dig, exp_fd, exp_nib}) begin
        errors++;
        $display("FAIL scan cyc=%0d got seg=%h dig=%b fd=%b nib=%h want seg=%h dig=%b fd=%b nib=%h",
                 cyc, seg_out, dig_out, frame_done, nibble_out, exp_seg, exp_dig, exp_fd, exp_nib);
      end
      wn = digit_of(16'h1234, (k / P) % 4);
      checks++;
      if (nibble_out !== wn) begin errors++; $display("FAIL scan_nib cyc=%0d got %h want %h", cyc, nibble_out, wn); end
      if (dig_out !== 4'hF) begin
        checks++;
        if (seg_out !== {1'b1, pseg[6:0]}) begin
          errors++; $display("FAIL scan_seg cyc=%0d got %h want %h", cyc, seg_out, {1'b1, pseg[6:0]});
        end
      end
      if (dig_out === 4'hF) dark++;
      for (int d = 0; d < 4; d++) if (dig_out === low_at(d)) lows[d]++;
      if (frame_done === 1'b1) fd_at.push_back(cyc);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lows[d] != 2 * (P - B)) begin errors++; $display("FAIL scan_lit d=%0d got %0d want %0d", d, lows[d], 2 * (P - B)); end
    end
    checks++;
    if (dark != 8 * B) begin errors++; $display("FAIL scan_dark got %0d want %0d", dark, 8 * B); end
    checks++;
    if (fd_at.size() != 2) begin
      errors++; $display("FAIL scan_fd_count got %0d want 2", fd_at.size());
    end else begin
      checks++;
      if (fd_at[1] - fd_at[0] != FRAME) begin
        errors++; $display("FAIL scan_fd_period got %0d want %0d", fd_at[1] - fd_at[0], FRAME);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [3:0] wn;
    goto(1, 3);
    pulse_load(16'hAAAA);
    goto(2, 4);
    pulse_load(16'h5555);
    for (int i = 0; i < FRAME; i++) begin
      if (((k / P) % 4) == 3 && (k % P) == P - 1) break;
      wn = digit_of(16'h1234, (k / P) % 4);
      checks++;
      if (nibble_out !== wn) begin errors++; $display("FAIL tear_old cyc=%0d got %h want %h", cyc, nibble_out, wn); end
      tick();
    end
    tick();
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if ({seg_out, dig_out, frame_done, nibble_out} !== {exp_seg, exp_dig, exp_fd, exp_nib}) begin
        errors++;
        $display("FAIL tear cyc=%0d got seg=%h dig=%b fd=%b nib=%h want seg=%h dig=%b fd=%b nib=%h",
                 cyc, seg_out, dig_out, frame_done, nibble_out, exp_seg, exp_dig, exp_fd, exp_nib);
      end
      checks++;
      if (nibble_out !== 4'h5) begin errors++; $display("FAIL tear_new cyc=%0d got %h want 5", cyc, nibble_out); end
      tick();
    end
  endtask

  task automatic test_wrap_load();
    logic [3:0] wn;
    goto(1, 0);
    pulse_load(16'h1111);
    goto(3, P - 1);
    pulse_load(16'hBEEF);
    for (int i = 0; i < 2 * FRAME; i++) begin
      wn = digit_of(16'hBEEF, (k / P) % 4);
      checks++;
      if (nibble_out !== wn) begin errors++; $display("FAIL wrap_load cyc=%0d got %h want %h", cyc, nibble_out, wn); end
      tick();
      checks++;
      if ({seg_out, dig_out, frame_done} !== {exp_seg, exp_dig, exp_fd}) begin
        errors++;
        $display("FAIL wrap_pins cyc=%0d got seg=%h dig=%b fd=%b want seg=%h dig=%b fd=%b",
                 cyc, seg_out, dig_out, frame_done, exp_seg, exp_dig, exp_fd);
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals[3];
    logic        lzs[3];
    logic [6:0]  want[3][4];
    vals = '{16'h0040, 16'h0000, 16'h0000};
    lzs  = '{1'b1, 1'b1, 1'b0};
    want = '{'{7'h40, 7'h19, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}, '{7'h40, 7'h40, 7'h40, 7'h40}};
    for (int c = 0; c < 3; c++) begin
      goto(3, P - 1);
      blank_lz = lzs[c];
      pulse_load(vals[c]);
      for (int i = 0; i < FRAME; i++) begin
        tick();
        checks++;
        if ({seg_out, dig_out, frame_done, nibble_out} !== {exp_seg, exp_dig, exp_fd, exp_nib}) begin
          errors++;
          $display("FAIL lz case=%0d cyc=%0d got seg=%h dig=%b fd=%b nib=%h want seg=%h dig=%b fd=%b nib=%h",
                   c, cyc, seg_out, dig_out, frame_done, nibble_out, exp_seg, exp_dig, exp_fd, exp_nib);
        end
        for (int d = 0; d < 4; d++) begin
          if (dig_out === low_at(d)) begin
            checks++;
            if (seg_out[6:0] !== want[c][d]) begin
              errors++; $display("FAIL lz_digit case=%0d d=%0d got %h want %h", c, d, seg_out[6:0], want[c][d]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_dp();
    logic w7;
    dp_in = 4'b0100;
    tick();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      w7 = (dig_out === 4'b1011) ? 1'b0 : 1'b1;
      checks++;
      if (seg_out[7] !== w7) begin errors++; $display("FAIL dp cyc=%0d dig=%b got %b want %b", cyc, dig_out, seg_out[7], w7); end
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL dp_seg cyc=%0d got %h want %h", cyc, seg_out, exp_seg); end
    end
    dp_in = 4'h0;
  endtask

  task automatic test_reset_mid();
    goto(3, P - 1);
    pulse_load(16'h4321);
    goto(1, 2);
    pulse_load(16'h9876);
    goto(2, 5);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL midrst_seg got %h want ff", seg_out); end
    checks++; if (dig_out !== 4'hF) begin errors++; $display("FAIL midrst_dig got %b want 1111", dig_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd got %b want 0", frame_done); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      checks++;
      if (nibble_out !== 4'h0) begin errors++; $display("FAIL midrst_nib cyc=%0d got %h want 0", cyc, nibble_out); end
      tick();
      checks++;
      if ({seg_out, dig_out, frame_done} !== {exp_seg, exp_dig, exp_fd}) begin
        errors++;
        $display("FAIL midrst cyc=%0d got seg=%h dig=%b fd=%b want seg=%h dig=%b fd=%b",
                 cyc, seg_out, dig_out, frame_done, exp_seg, exp_dig, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 1500; i++) begin
      tick();
      checks++;
      if ({seg_out, dig_out, frame_done, nibble_out} !== {exp_seg, exp_dig, exp_fd, exp_nib}) begin
        errors++;
        $display("FAIL random cyc=%0d got seg=%h dig=%b fd=%b nib=%h want seg=%h dig=%b fd=%b nib=%h",
                 cyc, seg_out, dig_out, frame_done, nibble_out, exp_seg, exp_dig, exp_fd, exp_nib);
      end
      checks++;
      if ($countones(~dig_out) > 1) begin errors++; $display("FAIL random_onehot cyc=%0d got %b want at most one low", cyc, dig_out); end
      v = 16'($urandom);
      for (int n = 0; n < 4; n++) if ($urandom_range(0, 2) != 0) v[4*n +: 4] = 4'h0;
      value_in = v;
      load = (i % 200 < 20) ? 1'b1 : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      resetn = ($urandom_range(0, 299) != 0);
    end
    load = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_wrap_load();
    test_lz();
    test_dp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
